// File: rtl/fsm_ctrl_pkg.sv
// rtl/fsm_ctrl_pkg.sv - shared state encodings, default sizes and helpers for fsm_ctrl
package fsm_ctrl_pkg;

  localparam int DEF_NUM_FIFOS = 8;
  localparam int DEF_UMBRAL_W  = 8;

  localparam logic [2:0] ST_RESET  = 3'b000;
  localparam logic [2:0] ST_INIT   = 3'b001;
  localparam logic [2:0] ST_IDLE   = 3'b010;
  localparam logic [2:0] ST_ERROR  = 3'b011;
  localparam logic [2:0] ST_ACTIVE = 3'b100;

  // Lowest set bit wins; scanning downwards lets the last hit be the lowest index.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fsm_ctrl_if.sv
// rtl/fsm_ctrl_if.sv - bundle of fsm_ctrl configuration, FIFO status and flag signals
interface fsm_ctrl_if #(
  parameter int NUM_FIFOS = 8,
  parameter int UMBRAL_W  = 8
);

  logic                          init;
  logic [UMBRAL_W-1:0]           umbral_L;
  logic [UMBRAL_W-1:0]           umbral_H;
  logic [NUM_FIFOS-1:0]          fifo_empty;
  logic [NUM_FIFOS*UMBRAL_W-1:0] fifo_occ;
  logic [NUM_FIFOS-1:0]          fifo_error;
  logic [2:0]                    state;
  logic [UMBRAL_W-1:0]           umbral_L_out;
  logic [UMBRAL_W-1:0]           umbral_H_out;
  logic [NUM_FIFOS-1:0]          almost_empty;
  logic [NUM_FIFOS-1:0]          almost_full;
  logic                          pause;
  logic                          idle_out;
  logic                          error_out;
  logic                          cfg_error;
  logic [3:0]                    err_fifo_id;

  modport master (
    output init, umbral_L, umbral_H, fifo_empty, fifo_occ, fifo_error,
    input  state, umbral_L_out, umbral_H_out, almost_empty, almost_full,
    input  pause, idle_out, error_out, cfg_error, err_fifo_id
  );

  modport slave (
    input  init, umbral_L, umbral_H, fifo_empty, fifo_occ, fifo_error,
    output state, umbral_L_out, umbral_H_out, almost_empty, almost_full,
    output pause, idle_out, error_out, cfg_error, err_fifo_id
  );

endinterface

// File: rtl/fsm_ctrl_umbral_cmp.sv
// rtl/fsm_ctrl_umbral_cmp.sv - per-FIFO threshold comparison with registered almost flags
module umbral_cmp #(
  parameter int UMBRAL_W = 8
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                i_en,
  input  logic [UMBRAL_W-1:0] i_occ,
  input  logic [UMBRAL_W-1:0] i_umbral_L,
  input  logic [UMBRAL_W-1:0] i_umbral_H,
  output logic                o_af_next,
  output logic                o_almost_empty,
  output logic                o_almost_full
);

  logic w_af;
  logic w_ae;
  logic r_af;
  logic r_ae;

  assign w_af = i_en && (i_occ >= i_umbral_H);
  assign w_ae = i_en && (i_occ <= i_umbral_L);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_af <= 1'b0;
      r_ae <= 1'b0;
    end else begin
      r_af <= w_af;
      r_ae <= w_ae;
    end
  end

  // The unregistered full flag feeds the parent's pause register so both update on the same edge.
  assign o_af_next      = w_af;
  assign o_almost_full  = r_af;
  assign o_almost_empty = r_ae;

endmodule

// File: rtl/fsm_ctrl.sv
// rtl/fsm_ctrl.sv - FIFO monitor controller: config, idle/active/error FSM and backpressure
module fsm_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int UMBRAL_W  = DEF_UMBRAL_W
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic                          init,
  input  logic [UMBRAL_W-1:0]           umbral_L,
  input  logic [UMBRAL_W-1:0]           umbral_H,
  input  logic [NUM_FIFOS-1:0]          fifo_empty,
  input  logic [NUM_FIFOS*UMBRAL_W-1:0] fifo_occ,
  input  logic [NUM_FIFOS-1:0]          fifo_error,
  output logic [2:0]                    state,
  output logic [UMBRAL_W-1:0]           umbral_L_out,
  output logic [UMBRAL_W-1:0]           umbral_H_out,
  output logic [NUM_FIFOS-1:0]          almost_empty,
  output logic [NUM_FIFOS-1:0]          almost_full,
  output logic                          pause,
  output logic                          idle_out,
  output logic                          error_out,
  output logic                          cfg_error,
  output logic [3:0]                    err_fifo_id
);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [UMBRAL_W-1:0]  r_umbral_L;
  logic [UMBRAL_W-1:0]  r_umbral_H;
  logic                 r_cfg_error;
  logic [3:0]           r_err_id;
  logic                 r_pause;
  logic                 w_cmp_en;
  logic [NUM_FIFOS-1:0] w_af_next;
  logic [15:0]          w_err16;

  always_comb begin
    w_next = ST_RESET;
    case (r_state)
      ST_RESET:  w_next = ST_INIT;
      ST_INIT:   w_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (|fifo_error)      w_next = ST_ERROR;
        else if (init)        w_next = ST_INIT;
        else if (&fifo_empty) w_next = ST_IDLE;
        else                  w_next = ST_ACTIVE;
      end
      ST_ERROR:  w_next = init ? ST_INIT : ST_ERROR;
      default:   w_next = ST_RESET;
    endcase
  end

  always_comb begin
    w_err16 = '0;
    w_err16[NUM_FIFOS-1:0] = fifo_error;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // A rejected request keeps the previous, known-good thresholds in force.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_umbral_L  <= '0;
      r_umbral_H  <= '0;
      r_cfg_error <= 1'b0;
    end else if (r_state == ST_INIT && init) begin
      if (umbral_L <= umbral_H) begin
        r_umbral_L  <= umbral_L;
        r_umbral_H  <= umbral_H;
        r_cfg_error <= 1'b0;
      end else begin
        r_cfg_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_err_id <= 4'd0;
    end else if (w_next == ST_ERROR && r_state != ST_ERROR) begin
      r_err_id <= lowest_set(w_err16);
    end
  end

  assign w_cmp_en = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_cmp
    umbral_cmp #(
      .UMBRAL_W(UMBRAL_W)
    ) u_cmp (
      .clk           (clk),
      .reset_L       (reset_L),
      .i_en          (w_cmp_en),
      .i_occ         (fifo_occ[g*UMBRAL_W +: UMBRAL_W]),
      .i_umbral_L    (r_umbral_L),
      .i_umbral_H    (r_umbral_H),
      .o_af_next     (w_af_next[g]),
      .o_almost_empty(almost_empty[g]),
      .o_almost_full (almost_full[g])
    );
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_pause <= 1'b0;
    end else begin
      r_pause <= (|w_af_next) || (w_next == ST_ERROR);
    end
  end

  assign state        = r_state;
  assign umbral_L_out = r_umbral_L;
  assign umbral_H_out = r_umbral_H;
  assign cfg_error    = r_cfg_error;
  assign err_fifo_id  = r_err_id;
  assign pause        = r_pause;
  assign idle_out     = (r_state == ST_IDLE);
  assign error_out    = (r_state == ST_ERROR);

endmodule

// File: tb/tb_fsm_ctrl.sv
// tb/tb_fsm_ctrl.sv - self-checking bench for fsm_ctrl against a rule-level reference model
module tb_fsm_ctrl;

  localparam int NF = 8;
  localparam int UW = 8;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ERROR = 3, S_ACTIVE = 4;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  fsm_ctrl_if #(.NUM_FIFOS(NF), .UMBRAL_W(UW)) bus ();

  fsm_ctrl #(.NUM_FIFOS(NF), .UMBRAL_W(UW)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .init        (bus.init),
    .umbral_L    (bus.umbral_L),
    .umbral_H    (bus.umbral_H),
    .fifo_empty  (bus.fifo_empty),
    .fifo_occ    (bus.fifo_occ),
    .fifo_error  (bus.fifo_error),
    .state       (bus.state),
    .umbral_L_out(bus.umbral_L_out),
    .umbral_H_out(bus.umbral_H_out),
    .almost_empty(bus.almost_empty),
    .almost_full (bus.almost_full),
    .pause       (bus.pause),
    .idle_out    (bus.idle_out),
    .error_out   (bus.error_out),
    .cfg_error   (bus.cfg_error),
    .err_fifo_id (bus.err_fifo_id)
  );

  int n_err = 0;
  int n_chk = 0;

  int          m_state;
  int          m_L, m_H, m_eid;
  bit          m_cfg, m_pause;
  bit [NF-1:0] m_ae, m_af;

  wire [42:0] obs = {bus.state, bus.umbral_L_out, bus.umbral_H_out, bus.cfg_error,
                     bus.err_fifo_id, bus.almost_empty, bus.almost_full, bus.pause,
                     bus.idle_out, bus.error_out};

  function automatic logic [42:0] expv();
    return {3'(m_state), 8'(m_L), 8'(m_H), m_cfg, 4'(m_eid), m_ae, m_af, m_pause,
            m_state == S_IDLE, m_state == S_ERROR};
  endfunction

  function automatic int occ_of(int i);
    return int'(bus.fifo_occ[i*UW +: UW]);
  endfunction

  task automatic model_reset();
    m_state = S_RESET; m_L = 0; m_H = 0; m_eid = 0;
    m_cfg = 0; m_pause = 0; m_ae = '0; m_af = '0;
  endtask

  task automatic model_edge();
    int cur, nxt;
    bit any_err;
    cur = m_state;
    any_err = (bus.fifo_error != '0);
    if (!reset_L) begin
      model_reset();
      return;
    end
    if (cur == S_RESET) nxt = S_INIT;
    else if (cur == S_INIT) nxt = bus.init ? S_INIT : S_IDLE;
    else if (cur == S_ERROR) nxt = bus.init ? S_INIT : S_ERROR;
    else if (any_err) nxt = S_ERROR;
    else if (bus.init) nxt = S_INIT;
    else if (bus.fifo_empty == '1) nxt = S_IDLE;
    else nxt = S_ACTIVE;
    for (int i = 0; i < NF; i++) begin
      m_af[i] = (cur == S_IDLE || cur == S_ACTIVE) && (occ_of(i) >= m_H);
      m_ae[i] = (cur == S_IDLE || cur == S_ACTIVE) && (occ_of(i) <= m_L);
    end
    m_pause = (m_af != '0) || (nxt == S_ERROR);
    if (cur == S_INIT && bus.init) begin
      if (int'(bus.umbral_L) <= int'(bus.umbral_H)) begin
        m_L = int'(bus.umbral_L); m_H = int'(bus.umbral_H); m_cfg = 0;
      end else begin
        m_cfg = 1;
      end
    end
    if (nxt == S_ERROR && cur != S_ERROR) begin
      for (int i = NF - 1; i >= 0; i--) if (bus.fifo_error[i]) m_eid = i;
    end
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_occ(int i, int v);
    bus.fifo_occ[i*UW +: UW] = 8'(v);
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (obs !== 43'h0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", obs);
    end
    tick();
    n_chk++;
    if (bus.state !== 3'b000) begin
      n_err++; $display("FAIL reset_hold: state %b want 000", bus.state);
    end
  endtask

  task automatic test_config();
    #1 reset_L = 1'b1;
    bus.init = 1'b1; bus.umbral_L = 8'd2; bus.umbral_H = 8'd6;
    tick();
    n_chk++;
    if (bus.state !== 3'b001) begin
      n_err++; $display("FAIL cfg_to_init: state %b want 001", bus.state);
    end
    tick();
    n_chk++;
    if (bus.umbral_L_out !== 8'd2 || bus.umbral_H_out !== 8'd6) begin
      n_err++; $display("FAIL cfg_load: L/H %0d/%0d want 2/6", bus.umbral_L_out, bus.umbral_H_out);
    end
    bus.init = 1'b0;
    tick();
    n_chk++;
    if (bus.state !== 3'b010 || bus.idle_out !== 1'b1) begin
      n_err++; $display("FAIL cfg_idle: state %b idle %b want 010/1", bus.state, bus.idle_out);
    end
    n_chk++;
    if (obs !== expv()) begin
      n_err++; $display("FAIL cfg_model: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_bad_config();
    bus.init = 1'b1; bus.umbral_L = 8'd7; bus.umbral_H = 8'd3;
    tick();
    tick();
    n_chk++;
    if (bus.umbral_L_out !== 8'd2 || bus.umbral_H_out !== 8'd6 || bus.cfg_error !== 1'b1) begin
      n_err++; $display("FAIL bad_cfg: L/H %0d/%0d cfg_err %b want 2/6/1",
                        bus.umbral_L_out, bus.umbral_H_out, bus.cfg_error);
    end
    bus.umbral_L = 8'd3; bus.umbral_H = 8'd7;
    tick();
    n_chk++;
    if (bus.cfg_error !== 1'b0 || bus.umbral_L_out !== 8'd3 || bus.umbral_H_out !== 8'd7) begin
      n_err++; $display("FAIL good_cfg: L/H %0d/%0d cfg_err %b want 3/7/0",
                        bus.umbral_L_out, bus.umbral_H_out, bus.cfg_error);
    end
    bus.umbral_L = 8'd2; bus.umbral_H = 8'd6;
    tick();
    bus.init = 1'b0;
    tick();
    n_chk++;
    if (obs !== expv() || bus.state !== 3'b010) begin
      n_err++; $display("FAIL recfg_model: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_active();
    bus.fifo_empty[3] = 1'b0; set_occ(3, 6);
    tick();
    n_chk++;
    if (bus.state !== 3'b100) begin
      n_err++; $display("FAIL to_active: state %b want 100", bus.state);
    end
    n_chk++;
    if (bus.almost_full[3] !== 1'b1 || bus.pause !== 1'b1) begin
      n_err++; $display("FAIL af3_pause: af3 %b pause %b want 1/1", bus.almost_full[3], bus.pause);
    end
    n_chk++;
    if (obs !== expv()) begin
      n_err++; $display("FAIL active_model: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_almost_empty();
    set_occ(3, 5); set_occ(0, 2);
    tick();
    n_chk++;
    if (bus.almost_empty[0] !== 1'b1 || bus.pause !== 1'b0) begin
      n_err++; $display("FAIL ae0_at_L: ae0 %b pause %b want 1/0", bus.almost_empty[0], bus.pause);
    end
    set_occ(0, 3);
    tick();
    n_chk++;
    if (bus.almost_empty[0] !== 1'b0) begin
      n_err++; $display("FAIL ae0_above_L: ae0 %b want 0", bus.almost_empty[0]);
    end
    bus.fifo_empty = '1; set_occ(0, 0); set_occ(3, 0);
    tick();
    n_chk++;
    if (bus.state !== 3'b010 || obs !== expv()) begin
      n_err++; $display("FAIL back_idle: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_error();
    bus.fifo_empty[3] = 1'b0;
    tick();
    bus.fifo_error = 8'b0010_0100; bus.init = 1'b1;
    tick();
    n_chk++;
    if (bus.state !== 3'b011 || bus.err_fifo_id !== 4'd2 || bus.pause !== 1'b1 ||
        bus.error_out !== 1'b1) begin
      n_err++; $display("FAIL err_entry: state %b id %0d pause %b err %b want 011/2/1/1",
                        bus.state, bus.err_fifo_id, bus.pause, bus.error_out);
    end
    bus.init = 1'b0;
    tick();
    n_chk++;
    if (bus.state !== 3'b011 || obs !== expv()) begin
      n_err++; $display("FAIL err_hold: got %h want %h", obs, expv());
    end
    bus.init = 1'b1; bus.fifo_error = 8'h01;
    tick();
    n_chk++;
    if (bus.state !== 3'b001 || bus.err_fifo_id !== 4'd2) begin
      n_err++; $display("FAIL err_exit: state %b id %0d want 001/2", bus.state, bus.err_fifo_id);
    end
    bus.init = 1'b0; bus.fifo_error = '0; bus.fifo_empty = '1;
    tick();
  endtask

  task automatic test_async_reset();
    bus.fifo_empty[3] = 1'b0; set_occ(3, 6);
    tick();
    n_chk++;
    if (bus.state !== 3'b100) begin
      n_err++; $display("FAIL pre_reset_active: state %b want 100", bus.state);
    end
    #2 reset_L = 1'b0;
    #1;
    n_chk++;
    if (obs !== 43'h0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", obs);
    end
    model_reset();
    #1 reset_L = 1'b1;
    bus.fifo_empty = '1; set_occ(3, 0);
    tick();
    n_chk++;
    if (bus.state !== 3'b001) begin
      n_err++; $display("FAIL reset_recover: state %b want 001", bus.state);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.init     = ($urandom % 8 == 0);
      bus.umbral_L = 8'($urandom_range(0, 15));
      bus.umbral_H = 8'($urandom_range(0, 15));
      bus.fifo_empty = ($urandom % 4 == 0) ? '1 : NF'($urandom);
      for (int i = 0; i < NF; i++) set_occ(i, $urandom_range(0, 15));
      bus.fifo_error = ($urandom % 16 == 0) ? NF'($urandom) : '0;
      tick();
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL random_cycle %0d: got %h want %h", c, obs, expv());
      end
    end
  endtask

  initial begin
    bus.init = 1'b0; bus.umbral_L = '0; bus.umbral_H = '0;
    bus.fifo_empty = '1; bus.fifo_occ = '0; bus.fifo_error = '0;
    model_reset();
    test_reset();
    test_config();
    test_bad_config();
    test_active();
    test_almost_empty();
    test_error();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl.md
FSM_CTRL -- requirements
Module: fsm_ctrl

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 8, giving the number of monitored FIFOs (range 1..16).
REQ-002 SHALL have parameter UMBRAL_W, default 8, giving the threshold and occupancy width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port init  input  1  configuration request; thresholds are latched while it is high.
REQ-006 SHALL have ports umbral_L, umbral_H  input  UMBRAL_W each  low and high threshold candidates.
REQ-007 SHALL have port fifo_empty  input  NUM_FIFOS  per-FIFO empty flags.
REQ-008 SHALL have port fifo_occ  input  NUM_FIFOS*UMBRAL_W  packed per-FIFO occupancy; FIFO i occupies bits [i*UMBRAL_W +: UMBRAL_W].
REQ-009 SHALL have port fifo_error  input  NUM_FIFOS  per-FIFO overflow/underflow flags.
REQ-010 SHALL have port state  output  3  current state register.
REQ-011 SHALL have ports umbral_L_out, umbral_H_out  output  UMBRAL_W each  latched thresholds.
REQ-012 SHALL have ports almost_empty, almost_full  output  NUM_FIFOS each  registered per-FIFO flags.
REQ-013 SHALL have port pause  output  1  registered upstream backpressure.
REQ-014 SHALL have ports idle_out, error_out  output  1 each  state decodes.
REQ-015 SHALL have port cfg_error  output  1  flag set when the last threshold request was rejected.
REQ-016 SHALL have port err_fifo_id  output  4  index of the FIFO that caused entry to ERROR.

Function
REQ-017 SHALL use state encodings RESET=000, INIT=001, IDLE=010, ERROR=011, ACTIVE=100; any other value SHALL go to RESET on the next edge.
REQ-018 SHALL move from RESET to INIT on the first edge with reset_L high.
REQ-019 In INIT: init=1 SHALL hold INIT; init=0 SHALL go to IDLE.
REQ-020 In INIT with init=1 and umbral_L<=umbral_H: umbral_L_out/umbral_H_out SHALL load the inputs at the edge and cfg_error SHALL clear.
REQ-021 In INIT with init=1 and umbral_L>umbral_H: the thresholds SHALL hold and cfg_error SHALL set at the edge.
REQ-022 IDLE/ACTIVE transition priority SHALL be: any fifo_error -> ERROR; else init=1 -> INIT; else all fifo_empty=1 -> IDLE; else -> ACTIVE.
REQ-023 On entry to ERROR, err_fifo_id SHALL capture the lowest set fifo_error index and hold it until the next ERROR entry or reset.
REQ-024 ERROR SHALL hold until init=1, then go to INIT; fifo_error SHALL be ignored while in ERROR.
REQ-025 In IDLE/ACTIVE: almost_full[i] SHALL register (fifo_occ[i] >= umbral_H_out); almost_empty[i] SHALL register (fifo_occ[i] <= umbral_L_out); comparisons unsigned; latency 1 cycle.
REQ-026 In RESET, INIT and ERROR: almost_full and almost_empty SHALL register 0.
REQ-027 pause SHALL register (OR of the next almost_full values) OR (next state == ERROR), with 1-cycle latency.
REQ-028 idle_out SHALL equal (state==IDLE) and error_out SHALL equal (state==ERROR), each decoded from the state register.

Reset
REQ-029 reset_L=0 SHALL immediately, without a clock, force state=RESET and every other output and register to 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending transitions; recovery SHALL follow REQ-018.

Structure
REQ-031 State encodings and the default NUM_FIFOS/UMBRAL_W values SHALL live in shared package fsm_ctrl_pkg.
REQ-032 Per-FIFO threshold comparison and flag registers SHALL be sub-module umbral_cmp, instantiated NUM_FIFOS times with a generate loop.

Verification (NUM_FIFOS=8, UMBRAL_W=8)
REQ-033 Config: release reset, init=1, L=2, H=6 for 2 cycles, then init=0.
- Required: INIT, then umbral_L_out=2, umbral_H_out=6, then IDLE with idle_out=1.
REQ-034 Bad config: init=1, L=7, H=3.
- Required: outputs stay 2/6 and cfg_error=1.
- Then L=3, H=7: cfg_error=0.
REQ-035 fifo_empty[3]=0 and occ[3]=6 in IDLE.
- Required: ACTIVE at the next edge.
- Required: almost_full[3]=1 and pause=1 one cycle after the stimulus.
REQ-036 occ[0]=2 gives almost_empty[0]=1; occ[0]=3 gives 0; all empties=1 gives a return to IDLE.
REQ-037 In ACTIVE, fifo_error[5] and [2] high with init=1 at the same time.
- Required: ERROR, err_fifo_id=2, pause=1, error_out=1.
- Then init=1 gives INIT.
REQ-038 reset_L low between edges while in ACTIVE.
- Required: state=000 and all outputs 0 before the next edge.
